// File: rtl/usr_nibble_packer.sv
// Packs 4-bit nibbles into 4*NIBBLES-bit words using a two-deep store: an accumulator plus an output register.
// Define USR_PACKER_PARITY_EN to add the registered out_parity output.
module usr_nibble_packer #(
  parameter int NIBBLES   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [3:0]                     in_nibble,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [4*NIBBLES-1:0]           out_word,
  output logic [$clog2(NIBBLES+1)-1:0]   out_count,
  input  logic                           out_ready
`ifdef USR_PACKER_PARITY_EN
  ,
  output logic                           out_parity
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  acc_word_q, acc_word_d;
  logic [CW-1:0] acc_count_q, acc_count_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_word_q, out_word_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          in_ready_q, in_ready_d;

  logic          accept;
  logic          take;
  logic          complete;
  logic [W-1:0]  merged_word;
  logic [CW-1:0] merged_count;

  always_comb begin
    state_d      = state_q;
    acc_word_d   = acc_word_q;
    acc_count_d  = acc_count_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    out_count_d  = out_count_q;

    merged_word = acc_word_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (acc_count_q == CW'(i)) begin
        if (MSB_FIRST) merged_word[4*(NIBBLES-1-i) +: 4] = in_nibble;
        else           merged_word[4*i +: 4]             = in_nibble;
      end
    end
    merged_count = acc_count_q + CW'(1);

    accept   = in_valid && in_ready_q;
    take     = out_valid_q && out_ready;
    complete = accept && ((merged_count == CW'(NIBBLES)) || in_last);

    if (take) out_valid_d = 1'b0;

    if (state_q == FILL) begin
      if (complete) begin
        // A same-edge take frees the output register, so the new word can go straight in.
        if (!out_valid_q || take) begin
          out_valid_d = 1'b1;
          out_word_d  = merged_word;
          out_count_d = merged_count;
          acc_word_d  = '0;
          acc_count_d = '0;
        end else begin
          state_d     = PEND;
          acc_word_d  = merged_word;
          acc_count_d = merged_count;
        end
      end else if (accept) begin
        acc_word_d  = merged_word;
        acc_count_d = merged_count;
      end
    end else if (take) begin
      out_valid_d = 1'b1;
      out_word_d  = acc_word_q;
      out_count_d = acc_count_q;
      acc_word_d  = '0;
      acc_count_d = '0;
      state_d     = FILL;
    end

    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      acc_word_q  <= '0;
      acc_count_q <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_count_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_word_q  <= acc_word_d;
      acc_count_q <= acc_count_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_count_q <= out_count_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_count = out_count_q;

`ifdef USR_PACKER_PARITY_EN
  logic out_parity_q, out_parity_d;

  always_comb begin
    out_parity_d = ^out_word_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) out_parity_q <= 1'b0;
    else        out_parity_q <= out_parity_d;
  end

  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_usr_nibble_packer.sv
// Directed bench for usr_nibble_packer: a queue-based word model checked every cycle on MSB- and LSB-first instances,
// plus literal expectations from hand-computed vectors.
module tb_usr_nibble_packer;

  localparam int NIB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_nibble = 4'h0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready_m, out_valid_m, in_ready_l, out_valid_l;
  logic [15:0] out_word_m, out_word_l;
  logic [2:0]  out_count_m, out_count_l;
`ifdef USR_PACKER_PARITY_EN
  logic        out_parity_m, out_parity_l;
`endif

  int n_vectors = 0;
  int n_miscompares = 0;

  usr_nibble_packer #(.NIBBLES(NIB), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_nibble(in_nibble), .in_last(in_last),
    .in_ready(in_ready_m), .out_valid(out_valid_m), .out_word(out_word_m), .out_count(out_count_m),
    .out_ready(out_ready)
`ifdef USR_PACKER_PARITY_EN
    , .out_parity(out_parity_m)
`endif
  );

  usr_nibble_packer #(.NIBBLES(NIB), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_nibble(in_nibble), .in_last(in_last),
    .in_ready(in_ready_l), .out_valid(out_valid_l), .out_word(out_word_l), .out_count(out_count_l),
    .out_ready(out_ready)
`ifdef USR_PACKER_PARITY_EN
    , .out_parity(out_parity_l)
`endif
  );

  always #5 clock = ~clock;

  // Model: words are kept as nibble lists in arrival order; alignment is applied only when comparing.
  typedef struct {
    logic [31:0] nibs;
    int          cnt;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] part_nibs = '0;
  int          part_cnt = 0;
  bit          model_in_ready = 1'b0;
  bit          m_acc, m_take;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      part_nibs      = '0;
      part_cnt       = 0;
      model_in_ready = 1'b0;
    end else begin
      m_acc  = in_valid && model_in_ready;
      m_take = (exp_q.size() > 0) && out_ready;
      if (m_take) void'(exp_q.pop_front());
      if (m_acc) begin
        part_nibs[4*part_cnt +: 4] = in_nibble;
        part_cnt++;
        if (part_cnt == NIB || in_last) begin
          exp_q.push_back('{part_nibs, part_cnt});
          part_nibs = '0;
          part_cnt  = 0;
        end
      end
      model_in_ready = (exp_q.size() < 2);
    end
  end

  function automatic logic [15:0] expWord(input logic [31:0] nibs, input int cnt, input bit msb);
    logic [15:0] w = '0;
    for (int k = 0; k < cnt; k++) begin
      if (msb) w = w | (16'(nibs[4*k +: 4]) << (4 * (NIB - 1 - k)));
      else     w = w | (16'(nibs[4*k +: 4]) << (4 * k));
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      checkOutput("in_ready_msb", 32'(in_ready_m), 32'(model_in_ready));
      checkOutput("in_ready_lsb", 32'(in_ready_l), 32'(model_in_ready));
      checkOutput("out_valid_msb", 32'(out_valid_m), 32'(exp_q.size() > 0));
      checkOutput("out_valid_lsb", 32'(out_valid_l), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        checkOutput("model_word_msb", 32'(out_word_m), 32'(expWord(exp_q[0].nibs, exp_q[0].cnt, 1'b1)));
        checkOutput("model_word_lsb", 32'(out_word_l), 32'(expWord(exp_q[0].nibs, exp_q[0].cnt, 1'b0)));
        checkOutput("model_count", 32'(out_count_m), 32'(exp_q[0].cnt));
        checkOutput("model_count_lsb", 32'(out_count_l), 32'(exp_q[0].cnt));
`ifdef USR_PACKER_PARITY_EN
        checkOutput("model_parity", 32'(out_parity_m), 32'(^expWord(exp_q[0].nibs, exp_q[0].cnt, 1'b1)));
        checkOutput("model_parity_lsb", 32'(out_parity_l), 32'(^expWord(exp_q[0].nibs, exp_q[0].cnt, 1'b0)));
`endif
      end
    end
  end

  // Presents one nibble and holds it until the model says it was accepted; returns at posedge+1.
  task automatic applyStimulus(input logic [3:0] n, input logic last);
    bit accepted;
    int budget = 0;
    in_valid  = 1'b1;
    in_nibble = n;
    in_last   = last;
    forever begin
      accepted = model_in_ready;
      @(posedge clock);
      #1;
      if (accepted) break;
      budget++;
      if (budget > 50) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL accept_timeout: nibble %0h not accepted, expected acceptance within 50 cycles", n);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    // Reset held for three edges
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_in_ready", 32'(in_ready_m), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid_m), 32'h0);
    checkOutput("rst_out_word", 32'(out_word_m), 32'h0);
    checkOutput("rst_out_count", 32'(out_count_m), 32'h0);
`ifdef USR_PACKER_PARITY_EN
    checkOutput("rst_out_parity", 32'(out_parity_m), 32'h0);
`endif
    reset = 1'b1;
    #1;
    checkOutput("release_in_ready_before_edge", 32'(in_ready_m), 32'h0);
    @(negedge clock);
    checkOutput("release_in_ready_after_edge", 32'(in_ready_m), 32'h1);

    // Full word, back to back
    out_ready = 1'b1;
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'h4, 1'b0);
    @(negedge clock);
    checkOutput("full_valid", 32'(out_valid_m), 32'h1);
    checkOutput("full_word", 32'(out_word_m), 32'h1234);
    checkOutput("full_count", 32'(out_count_m), 32'h4);
    checkOutput("full_word_lsb", 32'(out_word_l), 32'h4321);
    @(negedge clock);
    checkOutput("full_valid_drop", 32'(out_valid_m), 32'h0);

    // Early close and alignment
    applyStimulus(4'hA, 1'b0);
    applyStimulus(4'hB, 1'b1);
    @(negedge clock);
    checkOutput("early_word_msb", 32'(out_word_m), 32'hAB00);
    checkOutput("early_word_lsb", 32'(out_word_l), 32'h00BA);
    checkOutput("early_count", 32'(out_count_m), 32'h2);
    applyStimulus(4'h7, 1'b1);
    @(negedge clock);
    checkOutput("single_word_msb", 32'(out_word_m), 32'h7000);
    checkOutput("single_word_lsb", 32'(out_word_l), 32'h0007);
    checkOutput("single_count", 32'(out_count_m), 32'h1);

    // Backpressure: second word parks in the accumulator
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) applyStimulus(4'(i), 1'b0);
    @(negedge clock);
    checkOutput("bp_in_ready", 32'(in_ready_m), 32'h0);
    checkOutput("bp_word", 32'(out_word_m), 32'h1234);
`ifdef USR_PACKER_PARITY_EN
    checkOutput("parity_1234", 32'(out_parity_m), 32'h1);
`endif
    in_valid  = 1'b1;
    in_nibble = 4'h9;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("bp_stall_in_ready", 32'(in_ready_m), 32'h0);
    checkOutput("bp_stable_word", 32'(out_word_m), 32'h1234);
    checkOutput("bp_stable_count", 32'(out_count_m), 32'h4);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    checkOutput("bp_next_word", 32'(out_word_m), 32'h5678);
    checkOutput("bp_next_valid", 32'(out_valid_m), 32'h1);
    checkOutput("bp_in_ready_back", 32'(in_ready_m), 32'h1);

    // Completion coinciding with a take while the output register is full
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(4'h1, 1'b0);
    @(negedge clock);
    checkOutput("ones_word", 32'(out_word_m), 32'h1111);
`ifdef USR_PACKER_PARITY_EN
    checkOutput("parity_1111", 32'(out_parity_m), 32'h0);
`endif
    applyStimulus(4'h5, 1'b0);
    applyStimulus(4'h6, 1'b0);
    applyStimulus(4'h7, 1'b0);
    out_ready = 1'b1;
    applyStimulus(4'h8, 1'b0);
    @(negedge clock);
    checkOutput("swap_valid", 32'(out_valid_m), 32'h1);
    checkOutput("swap_word", 32'(out_word_m), 32'h5678);

    // Reset mid-word discards the partial word
    @(posedge clock);
    #1;
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid_m), 32'h0);
    checkOutput("midrst_in_ready", 32'(in_ready_m), 32'h0);
    checkOutput("midrst_out_word", 32'(out_word_m), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(4'h5, 1'b0);
    applyStimulus(4'h6, 1'b0);
    applyStimulus(4'h7, 1'b0);
    applyStimulus(4'h8, 1'b0);
    @(negedge clock);
    checkOutput("midrst_word", 32'(out_word_m), 32'h5678);
    checkOutput("midrst_word_lsb", 32'(out_word_l), 32'h8765);
    checkOutput("midrst_count", 32'(out_count_m), 32'h4);

    repeat (4) @(posedge clock);
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/usr_nibble_packer.md
# usr_nibble_packer

Downstream consumer of the universal shift register's 4-bit `DATAOUT`. It accepts one nibble per handshake and packs consecutive nibbles into a `4*NIBBLES`-bit word. Each completed word is presented on a valid/ready output. A word also closes early when the producer marks a nibble as the last one. Word storage is two deep: an accumulator plus an output register. A registered `in_ready` provides backpressure to the shift-register control logic.

## Interface
- `NIBBLES`, default 4: nibbles per full word. Legal range is 2..8.
- `MSB_FIRST`, default 1:
  - 1: the first nibble lands in the most-significant nibble.
  - 0: the first nibble lands in bits [3:0].
- `clock` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low. Low clears all state.
- `in_valid` input, 1 bit: `in_nibble` is valid.
- `in_nibble` input, 4 bits: data, connected to USR `DATAOUT`.
- `in_last` input, 1 bit: closes the word with this nibble. Sampled only on an accepted beat.
- `in_ready` output, 1 bit: packer accepts a nibble this cycle. Registered.
- `out_valid` output, 1 bit: `out_word` is valid.
- `out_word` output, `4*NIBBLES` bits: packed word.
- `out_count` output, `$clog2(NIBBLES+1)` bits: number of nibbles in `out_word`, from 1 to `NIBBLES`.
- `out_ready` input, 1 bit: consumer takes `out_word` this cycle.

## Operation
- Accept rule: a nibble is accepted when `in_valid && in_ready` at a rising edge.
- Transfer rule: a word is taken when `out_valid && out_ready` at a rising edge.
- States:
  - FILL: accumulating nibbles.
  - PEND: the accumulator holds a completed word, and the output register is still occupied.
- `in_ready` is 1 in FILL and 0 in PEND. It is 0 while `reset` is low, and becomes 1 after the first clock edge following reset release.
- Accumulate: the accepted nibble is written at position `acc_count`, and `acc_count` increments.
- Completion: the word completes when the accepted nibble makes `acc_count == NIBBLES`, or when `in_last` is 1.
  - If the output register is empty, or is being taken this same edge: move the word to the output register, clear the accumulator, stay in FILL.
  - Otherwise: go to PEND, holding the word and its count.
- In PEND: on the edge where the output word is taken, move the accumulator to the output register, clear the accumulator, and return to FILL.
- Partial words:
  - `MSB_FIRST=1`: left-aligned, first nibble in the top nibble, unused low nibbles are 0.
  - `MSB_FIRST=0`: right-aligned, unused high nibbles are 0.
- `in_last` on the first nibble of a word yields a one-nibble word with `out_count=1`.
- Output stability: `out_word` and `out_count` are held stable while `out_valid=1 && out_ready=0`.
- Reset mid-word: any partial word and any pending word are discarded.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_word=0`, `out_count=0`, state FILL, `acc_count=0`. With the macro defined, also `out_parity=0`.
- Latency: completing nibble accepted at edge N → `out_valid=1` after edge N. Latency is one cycle.
- Throughput: one nibble per cycle sustained when `out_ready=1` continuously.
- `in_ready` has no combinational path from `out_ready`.
- `out_valid` drops after the taking edge, unless a pending word or a same-edge completion reloads the output register.
- Back-to-back word transfers are possible on consecutive cycles.
- Simultaneous completion and take, with the output register full, in FILL: the new word replaces the taken word, and `out_valid` stays 1.

## Configuration
- Macro: `USR_PACKER_PARITY_EN`.
- Defined:
  - Adds output `out_parity` (1 bit): XOR of all `out_word` bits, registered alongside `out_word`.
  - `out_parity` is 1 when the word has an odd number of ones.
  - It is held stable under backpressure, like `out_word`.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
Settings for all scenarios: `NIBBLES=4`, `MSB_FIRST=1` unless stated.
- Reset: hold `reset=0` for 3 edges → all outputs 0 and `in_ready=0`. Release → `in_ready=1` after the first edge.
- Full word: nibbles 1, 2, 3, 4 back-to-back with `out_ready=1` → one cycle after the 4th nibble, `out_word=16'h1234`, `out_count=4`, `out_valid` for one cycle.
- Early close and alignment:
  - `MSB_FIRST=1`: nibbles A, B with `in_last` on B → `out_word=16'hAB00`, `out_count=2`.
  - `MSB_FIRST=0`: same stimulus → `16'h00BA`.
- Backpressure:
  - Stimulus: `out_ready=0`, then nibbles 1–8.
  - After the 8th nibble: `in_ready=0` (PEND), and `out_word` holds `16'h1234`.
  - The 9th nibble is stalled.
  - Raise `out_ready` → `16'h1234` is taken, then `16'h5678` appears the next cycle, and `in_ready` returns to 1.
- Reset mid-word: accept nibbles 1, 2, then pulse `reset` low → outputs clear. Then feed 5, 6, 7, 8 → `out_word=16'h5678`, `out_count=4`.
- Parity (`USR_PACKER_PARITY_EN` defined):
  - `16'h1234` → `out_parity=1`.
  - `16'h1111` → `out_parity=0`.
